// File: rtl/interleaver_pkg.sv
// Shared types and address mapping for the turbo-decoder deinterleaver.
// deint_addr() is the only piece that changes when the final permutation is adopted.
package interleaver_pkg;

    localparam int unsigned N_DEFAULT = 10;
    localparam int unsigned W_DEFAULT = 6;

    typedef logic signed [W_DEFAULT-1:0] soft_t;

    typedef enum logic [1:0] {
        BankEmpty    = 2'd0,
        BankFilling  = 2'd1,
        BankFull     = 2'd2,
        BankDraining = 2'd3
    } bank_state_e;

    // Interim permutation: beat i lands in slot (i+N-1)%N, so out[j] = in[(j+1)%N].
    function automatic int unsigned deint_addr(input int unsigned i,
                                               input int unsigned n = N_DEFAULT);
        return (i + n - 1) % n;
    endfunction

endpackage

// File: rtl/pingpong_buffer.sv
// Two-bank soft-value store: one synchronous write port, one combinational read port.
module pingpong_buffer #(
    parameter int unsigned Depth = 10,
    parameter int unsigned Width = 6,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic             wr_bank,
    input  logic [AW-1:0]    wr_addr,
    input  logic [Width-1:0] wr_data,
    input  logic             rd_bank,
    input  logic [AW-1:0]    rd_addr,
    output logic [Width-1:0] rd_data
);

    logic [Width-1:0] mem [2][Depth];

    // Storage write; contents need no reset since bank state gates every read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_bank][rd_addr];

endmodule

// File: rtl/stream_deinterleaver.sv
// Streaming deinterleaver: frames arrive in interleaved order and leave in natural order.
// Ping-pong banks let one frame fill while the previous one drains.
module stream_deinterleaver
    import interleaver_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT,
    parameter int unsigned W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         frame_err
);

    localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0] LastIdx = AW'(N - 1);

    logic [AW-1:0] wr_idx_q, wr_idx_d;
    logic [AW-1:0] rd_idx_q, rd_idx_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic          frame_err_q, frame_err_d;
    bank_state_e   state_q [2];
    bank_state_e   state_d [2];

    logic          in_fire;
    logic          out_fire;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  rd_data;

    // Handshake qualifiers derived purely from registered bank state.
    always_comb begin
        in_ready  = (state_q[wr_bank_q] == BankEmpty) || (state_q[wr_bank_q] == BankFilling);
        out_valid = (state_q[rd_bank_q] == BankFull) || (state_q[rd_bank_q] == BankDraining);
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        wr_addr   = AW'(deint_addr(32'(wr_idx_q), N));
        out_last  = out_valid && (rd_idx_q == LastIdx);
        out_data  = out_valid ? rd_data : '0;
    end

    // Next-state for counters, bank states and the framing check.
    // Write and read sides always touch different banks when both fire.
    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        wr_bank_d   = wr_bank_q;
        rd_idx_d    = rd_idx_q;
        rd_bank_d   = rd_bank_q;
        frame_err_d = 1'b0;

        if (in_fire) begin
            if (wr_idx_q == LastIdx) begin
                // Count is authoritative: commit even if in_last was missing.
                state_d[wr_bank_q] = BankFull;
                wr_bank_d          = ~wr_bank_q;
                wr_idx_d           = '0;
                frame_err_d        = ~in_last;
            end else if (in_last) begin
                // Early end: drop the partial frame and reuse the same bank.
                state_d[wr_bank_q] = BankEmpty;
                wr_idx_d           = '0;
                frame_err_d        = 1'b1;
            end else begin
                state_d[wr_bank_q] = BankFilling;
                wr_idx_d           = wr_idx_q + AW'(1);
            end
        end

        if (out_fire) begin
            if (rd_idx_q == LastIdx) begin
                state_d[rd_bank_q] = BankEmpty;
                rd_bank_d          = ~rd_bank_q;
                rd_idx_d           = '0;
            end else begin
                state_d[rd_bank_q] = BankDraining;
                rd_idx_d           = rd_idx_q + AW'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            frame_err_q <= 1'b0;
            state_q[0]  <= BankEmpty;
            state_q[1]  <= BankEmpty;
        end else begin
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            frame_err_q <= frame_err_d;
            state_q[0]  <= state_d[0];
            state_q[1]  <= state_d[1];
        end
    end

    assign frame_err = frame_err_q;

    pingpong_buffer #(
        .Depth (N),
        .Width (W),
        .AW    (AW)
    ) u_buffer (
        .clk     (clk),
        .we      (in_fire),
        .wr_bank (wr_bank_q),
        .wr_addr (wr_addr),
        .wr_data (in_data),
        .rd_bank (rd_bank_q),
        .rd_addr (rd_idx_q),
        .rd_data (rd_data)
    );

endmodule
